// File: rtl/unary_accum_pkg.sv
// Shared definitions for the unary bitstream accumulator: FSM encoding and
// frame-length helper.
package unary_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 10;

    // Number of valid samples in one frame for a given log2 frame length.
    function automatic int unsigned frame_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

    localparam int unsigned DEFAULT_FRAME_LEN = frame_len(DEFAULT_WIDTH);

endpackage

// File: rtl/unary_accum_lane_cnt.sv
// One lane: counts ones of a unary stream and compares the count against the
// frame's latched threshold.
module unary_lane_cnt #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             add,
    input  logic             sample,
    input  logic [WIDTH:0]   threshold,
    output logic [WIDTH:0]   count,
    output logic             above
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= {{WIDTH{1'b0}}, sample};
        end else if (add) begin
            count <= count + {{WIDTH{1'b0}}, sample};
        end
    end

    assign above = (count > threshold);

endmodule

// File: rtl/unary_accum.sv
// Accumulates LANES unary bitstreams over frames of 2**WIDTH valid samples and
// presents per-lane sums plus thresholded bits through a valid/ready output.
module unary_accum
    import unary_accum_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LANES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANES-1:0]           u_in,
    input  logic                       u_valid,
    input  logic                       frame_start,
    input  logic [WIDTH:0]             threshold,
    output logic [LANES*(WIDTH+1)-1:0] sum,
    output logic [LANES-1:0]           hv_bit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    output state_t                     fsm_state
);

    // Output handshake: a result is transferred in any cycle where
    // out_valid=1 and out_ready=1; out_valid and the result stay stable until then.

    localparam int unsigned FRAME_LEN   = frame_len(WIDTH);
    localparam state_t      START_STATE = (FRAME_LEN == 1) ? HOLD : ACCUM;

    state_t         state;
    state_t         state_next;
    logic [WIDTH:0] sample_cnt;
    logic [WIDTH:0] thr_q;
    logic           start;
    logic           last_sample;
    logic           lane_load;
    logic           lane_add;
    logic           set_overrun;

    always_comb begin
        start       = u_valid && frame_start && ((state != HOLD) || out_ready);
        last_sample = (32'(sample_cnt) == FRAME_LEN - 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = START_STATE;
            end
            ACCUM: begin
                if (start) state_next = START_STATE;
                else if (u_valid && last_sample) state_next = HOLD;
            end
            HOLD: begin
                if (start) state_next = START_STATE;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid   = (state == HOLD);
        lane_load   = start;
        lane_add    = (state == ACCUM) && u_valid && !frame_start;
        // A frame_start that cannot be honoured cleanly loses data somewhere.
        set_overrun = u_valid && frame_start &&
                      ((state == ACCUM) || ((state == HOLD) && !out_ready));
        fsm_state   = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt <= '0;
            thr_q      <= '0;
            overrun    <= 1'b0;
        end else begin
            if (lane_load) begin
                sample_cnt <= {{WIDTH{1'b0}}, 1'b1};
                thr_q      <= threshold;
            end else if (lane_add) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (set_overrun) overrun <= 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        unary_lane_cnt #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (lane_load),
            .add       (lane_add),
            .sample    (u_in[i]),
            .threshold (thr_q),
            .count     (sum[i*(WIDTH+1) +: WIDTH+1]),
            .above     (hv_bit[i])
        );
    end

endmodule

// File: tb/tb_unary_accum.sv
// Directed bench for unary_accum at WIDTH=10, LANES=4 with hand-computed sums.
module tb_unary_accum;
    import unary_accum_pkg::*;

    localparam int W = 10;
    localparam int L = 4;
    localparam int N = 1024;

    localparam logic [43:0] STD_SUM  = {11'd0, 11'd1024, 11'd256, 11'd512};
    localparam logic [43:0] ONES_SUM = {11'd1024, 11'd1024, 11'd1024, 11'd1024};
    localparam logic [43:0] PART_SUM = {11'd0, 11'd700, 11'd256, 11'd512};

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [L-1:0]   u_in = '0;
    logic           u_valid = 1'b0;
    logic           frame_start = 1'b0;
    logic [W:0]     threshold = '0;
    logic [43:0]    sum;
    logic [L-1:0]   hv_bit;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           overrun;
    state_t         fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    unary_accum #(.WIDTH(W), .LANES(L)) dut (
        .clk         (clk),
        .reset       (reset),
        .u_in        (u_in),
        .u_valid     (u_valid),
        .frame_start (frame_start),
        .threshold   (threshold),
        .sum         (sum),
        .hv_bit      (hv_bit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .fsm_state   (fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // mode 0: lane0 512 ones, lane1 256, lane2 all, lane3 none; mode 1: all ones
    function automatic logic [L-1:0] pat(input int mode, input int k);
        if (mode == 1) return 4'hF;
        return {1'b0, 1'b1, (k < 256), (k < 512)};
    endfunction

    // Called at a falling edge; applies inputs and returns at the next falling edge.
    task automatic drive(input logic v, input logic fs, input logic [L-1:0] u);
        u_valid     = v;
        frame_start = fs;
        u_in        = u;
        @(negedge clk);
    endtask

    task automatic run_frame(input int mode, input int first_k, input bit toggle,
                             input logic [W:0] thr);
        for (int k = first_k; k < N; k++) begin
            threshold = (k == 0) ? thr : 11'($urandom_range(0, 2047));
            drive(1'b1, (k == 0), pat(mode, k));
            if (k == N - 2) check("early_valid", out_valid, 0);
            if (toggle && k < N - 1)
                drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        check("valid_latency", out_valid, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_sum", sum, 0);
        check("rst_hv", hv_bit, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", fsm_state, IDLE);
        reset = 1'b1;

        repeat (3) drive(1'b1, 1'b0, 4'hF);
        check("idle_ignore_sum", sum, 0);
        check("idle_ignore_state", fsm_state, IDLE);

        // basic frame, always ready
        run_frame(0, 0, 0, 11'd512);
        check("basic_sum", sum, STD_SUM);
        check("basic_hv", hv_bit, 4'b0100);
        check("basic_overrun", overrun, 0);
        drive(1'b0, 1'b0, 4'h0);
        check("basic_ack_valid", out_valid, 0);
        check("basic_ack_state", fsm_state, IDLE);

        // u_valid toggling
        run_frame(0, 0, 1, 11'd512);
        check("stall_sum", sum, STD_SUM);
        check("stall_hv", hv_bit, 4'b0100);
        drive(1'b0, 1'b0, 4'h0);
        check("stall_ack_valid", out_valid, 0);

        // backpressure then back-to-back frame in the handshake cycle
        out_ready = 1'b0;
        run_frame(0, 0, 0, 11'd300);
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b0, 4'h0);
            check("bp_sum", sum, STD_SUM);
            check("bp_hv", hv_bit, 4'b0101);
            check("bp_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        threshold = 11'd512;
        drive(1'b1, 1'b1, pat(0, 0));
        check("b2b_valid", out_valid, 0);
        check("b2b_state", fsm_state, ACCUM);
        run_frame(0, 1, 0, 11'd512);
        check("b2b_sum", sum, STD_SUM);
        check("b2b_hv", hv_bit, 4'b0100);
        check("b2b_overrun", overrun, 0);
        drive(1'b0, 1'b0, 4'h0);

        // restart mid-frame at sample 300
        threshold = 11'd7;
        for (int k = 0; k < 300; k++) drive(1'b1, (k == 0), 4'hF);
        check("pre_restart_overrun", overrun, 0);
        check("pre_restart_state", fsm_state, ACCUM);
        run_frame(0, 0, 0, 11'd512);
        check("restart_overrun", overrun, 1);
        check("restart_sum", sum, STD_SUM);
        check("restart_hv", hv_bit, 4'b0100);
        drive(1'b0, 1'b0, 4'h0);

        // asynchronous reset at sample 700
        threshold = 11'd512;
        for (int k = 0; k < 700; k++) drive(1'b1, (k == 0), pat(0, k));
        check("partial_sum", sum, PART_SUM);
        reset = 1'b0;
        #1;
        check("areset_sum", sum, 0);
        check("areset_hv", hv_bit, 0);
        check("areset_valid", out_valid, 0);
        check("areset_overrun", overrun, 0);
        check("areset_state", fsm_state, IDLE);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 400; k++) drive(1'b1, 1'b0, 4'hF);
        check("post_reset_valid", out_valid, 0);
        check("post_reset_sum", sum, 0);
        out_ready = 1'b0;
        run_frame(0, 0, 0, 11'd512);
        check("fresh_sum", sum, STD_SUM);
        check("fresh_overrun", overrun, 0);

        // frame_start while holding without handshake is dropped
        drive(1'b1, 1'b1, 4'hF);
        check("drop_overrun", overrun, 1);
        check("drop_state", fsm_state, HOLD);
        check("drop_valid", out_valid, 1);
        check("drop_sum", sum, STD_SUM);
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 4'h0);
        check("drop_ack_valid", out_valid, 0);

        // full-ones frame: no wrap, threshold boundaries
        run_frame(1, 0, 0, 11'd1024);
        check("ones_sum", sum, ONES_SUM);
        check("ones_hv_1024", hv_bit, 4'b0000);
        drive(1'b0, 1'b0, 4'h0);
        run_frame(1, 0, 0, 11'd1023);
        check("ones_hv_1023", hv_bit, 4'b1111);
        drive(1'b0, 1'b0, 4'h0);
        check("final_state", fsm_state, IDLE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
